ps2_keyboard_matrix: RTL
========================

Name: ps2_keyboard_matrix

Overview:
- Receives PS/2 set-2 scancodes from an external keyboard and maintains a 40-key ZX matrix, 8 half-rows x 5 columns.
- Drives the kd[4:0] keyboard inputs of the ULA's port #FE read path.
- kd is a combinational function of CPU address A15..A8 and the held-key matrix, so an IN from #xxFE sees the keys pressed in every selected half-row.
- Runs on clkcpu, 3.5 MHz nominal.

Parameters:
- FILTER_LEN, 4: number of consecutive equal synchronized ps2_clk samples required before a level change is accepted.
- TIMEOUT_CYCLES, 7000: clkcpu cycles without a falling ps2_clk edge, while a frame is in progress, before the frame is abandoned (2 ms at 3.5 MHz).

Ports:
- clkcpu, input, 1: CPU clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- ps2_clk, input, 1: PS/2 clock from keyboard, asynchronous.
- ps2_dat, input, 1: PS/2 data from keyboard, asynchronous.
- addr_hi, input, 8: CPU A15..A8. Bit r low selects half-row r.
- kd, output, 5: column lines to port #FE, active-low, combinational.
- key_rst, output, 1: high while F12 is held. Used as a user reset request.

Behaviour:
- Reset: matrix cleared (all keys released), kd = 5'b11111, key_rst = 0, receiver in IDLE, break/extended flags cleared, filter and timeout counters = 0.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - ps2_clk is then deglitched: the filtered level changes only after FILTER_LEN identical samples.
  - A falling edge of the filtered clock is a one-cycle strobe, fall.
- Receiver FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. Every sample of ps2_dat is taken on the fall cycle.
  - IDLE: on fall, if dat=0 (start bit) go to DATA with bit count 0; otherwise stay in IDLE.
  - DATA: shift dat in LSB first. After the 8th bit go to PARITY.
  - PARITY: record the parity bit. Parity error if the XOR of the 8 data bits and the parity bit is 0 (odd parity required).
  - STOP: if dat=1 and parity is good, assert rx_valid for exactly 1 cycle with rx_byte. Otherwise discard the frame silently. Return to IDLE in either case.
  - Timeout counter clears on every fall. If it reaches TIMEOUT_CYCLES in any state other than IDLE, go to IDLE and discard the partial frame. The counter saturates; it does not wrap.
- Decoder, acting on rx_valid:
  - 0xF0 sets brk.
  - 0xE0 sets ext.
  - Any other byte is a key code. Apply it with pressed = ~brk, then clear brk and ext.
  - Non-extended mapping: letters, digits, 0x5A Enter -> (6,0), 0x29 Space -> (7,0), 0x12 or 0x59 Shift -> CAPS (0,0), 0x14 Ctrl -> SYMBOL SHIFT (7,1). All other letter and digit keys follow the standard ZX half-row layout. Example: 0x1C A -> (1,0); 0x16 "1" -> (3,0); 0x45 "0" -> (4,0).
  - 0x07 F12 sets or clears key_rst.
  - Unmapped codes, and any extended code unless PS2_EXTKEYS_EN is defined, are ignored but still clear the flags.
  - 0xAA (BAT OK) and 0xFA (ACK) are ignored.
- Matrix update occurs the cycle after rx_valid, i.e. 2 cycles after the cycle that samples the stop bit.
- kd[c] = NOT (OR over rows r with addr_hi[r]=0 of key[r][c]).
  - addr_hi = 8'hFF gives kd = 5'b11111.
  - addr_hi = 8'h00 ORs all rows.
- Repeated make codes (typematic) are idempotent. A break for a key not held is harmless.
- rst_n asserted mid-frame: immediate return to the reset state. The next frame must start with a valid start bit.

Optional Feature:
- Macro: PS2_EXTKEYS_EN.
- When defined, a separate composite matrix is ORed into the primary matrix to form kd:
  - Extended arrows E0 6B/74/72/75 (left/right/down/up) -> CAPS + 5/8/6/7.
  - 0x66 Backspace -> CAPS + 0.
  - Extended E0 14 (right Ctrl) -> SYMBOL SHIFT.
- Releasing a composite key clears only composite bits, so a physically held Shift stays pressed.
- When not defined, the composite matrix and the extended decode are absent, and all E0-prefixed codes are ignored.

Test Plan:
- Reset, then addr_hi=8'hFD -> kd=5'b11111, key_rst=0.
- Send frame 0x1C (start 0, data, parity 0, stop 1), then addr_hi=8'hFD -> kd=5'b11110. Send F0 1C -> kd=5'b11111.
- Send 1C with the parity bit flipped -> frame discarded, kd stays 5'b11111. The next valid 1C frame is accepted.
- Send 4 bits of a frame, idle 7000+ cycles, then a full 0x29 frame -> addr_hi=8'h7F gives kd=5'b11110. No misaligned byte is decoded.
- Hold 0x12 and 0x29, then addr_hi=8'h7E -> kd=5'b11110. Send F0 12 -> kd still 5'b11110 (Space held).
- With PS2_EXTKEYS_EN, hold Shift, send E0 6B then E0 F0 6B -> during the arrow, addr_hi=8'hEF... use 8'hF7: kd=5'b01111, and addr_hi=8'hFE: kd=5'b11110. After the arrow release, CAPS is still held (kd=5'b11110 at 8'hFE). Send F12 -> key_rst=1; send F0 07 -> key_rst=0.

Source files
------------

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 receiver that maintains the ZX 8x5 key matrix and drives the port #FE kd lines.
// Optional macro PS2_EXTKEYS_EN adds composite keys (arrows, Backspace, right Ctrl).
module ps2_keyboard_matrix #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 7000
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       key_rst
);
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          r_fall;
    logic          w_clk_s;
    logic          w_dat_s;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            r_fall     <= 1'b0;
            if (w_clk_s == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_LAST) begin
                r_clk_filt <= w_clk_s;
                r_filt_cnt <= '0;
                r_fall     <= ~w_clk_s;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic          r_rx_valid;
    logic [7:0]    r_rx_byte;

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b0;
            r_to_cnt   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            if (r_fall) begin
                case (r_state)
                    StIdle: begin
                        if (!w_dat_s) begin
                            r_state   <= StData;
                            r_bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= StParity;
                    end
                    StParity: begin
                        r_par_ok <= ^{r_shift, w_dat_s};
                        r_state  <= StStop;
                    end
                    default: begin
                        if (w_dat_s && r_par_ok) begin
                            r_rx_valid <= 1'b1;
                            r_rx_byte  <= r_shift;
                        end
                        r_state <= StIdle;
                    end
                endcase
            end else if (r_state != StIdle && r_to_cnt == TO_MAX) begin
                // Keyboard stalled mid-frame: drop the partial byte.
                r_state <= StIdle;
            end
        end
    end

    // Matrix position as octal {row, col}.
    logic       w_map_hit;
    logic [5:0] w_map_rc;
    logic [5:0] w_map_idx;

    always_comb begin
        w_map_hit = 1'b1;
        w_map_rc  = 6'o00;
        case (r_rx_byte)
            8'h12, 8'h59: w_map_rc = 6'o00;
            8'h1A: w_map_rc = 6'o01;  8'h22: w_map_rc = 6'o02;  8'h21: w_map_rc = 6'o03;
            8'h2A: w_map_rc = 6'o04;
            8'h1C: w_map_rc = 6'o10;  8'h1B: w_map_rc = 6'o11;  8'h23: w_map_rc = 6'o12;
            8'h2B: w_map_rc = 6'o13;  8'h34: w_map_rc = 6'o14;
            8'h15: w_map_rc = 6'o20;  8'h1D: w_map_rc = 6'o21;  8'h24: w_map_rc = 6'o22;
            8'h2D: w_map_rc = 6'o23;  8'h2C: w_map_rc = 6'o24;
            8'h16: w_map_rc = 6'o30;  8'h1E: w_map_rc = 6'o31;  8'h26: w_map_rc = 6'o32;
            8'h25: w_map_rc = 6'o33;  8'h2E: w_map_rc = 6'o34;
            8'h45: w_map_rc = 6'o40;  8'h46: w_map_rc = 6'o41;  8'h3E: w_map_rc = 6'o42;
            8'h3D: w_map_rc = 6'o43;  8'h36: w_map_rc = 6'o44;
            8'h4D: w_map_rc = 6'o50;  8'h44: w_map_rc = 6'o51;  8'h43: w_map_rc = 6'o52;
            8'h3C: w_map_rc = 6'o53;  8'h35: w_map_rc = 6'o54;
            8'h5A: w_map_rc = 6'o60;  8'h4B: w_map_rc = 6'o61;  8'h42: w_map_rc = 6'o62;
            8'h3B: w_map_rc = 6'o63;  8'h33: w_map_rc = 6'o64;
            8'h29: w_map_rc = 6'o70;  8'h14: w_map_rc = 6'o71;  8'h3A: w_map_rc = 6'o72;
            8'h31: w_map_rc = 6'o73;  8'h32: w_map_rc = 6'o74;
            default: w_map_hit = 1'b0;
        endcase
        w_map_idx = 6'(w_map_rc[5:3]) * 6'd5 + 6'(w_map_rc[2:0]);
    end

    logic        r_brk;
    logic        r_ext;
    logic        r_key_rst;
    logic [39:0] r_key;
    logic        w_key_ev;

    assign w_key_ev = r_rx_valid && r_rx_byte != 8'hF0 && r_rx_byte != 8'hE0 &&
                      r_rx_byte != 8'hAA && r_rx_byte != 8'hFA;

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_key_rst <= 1'b0;
            r_key     <= '0;
        end else if (r_rx_valid) begin
            if (r_rx_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_rx_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (w_key_ev) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (!r_ext && r_rx_byte == 8'h07) begin
                    r_key_rst <= ~r_brk;
                end else if (!r_ext && w_map_hit) begin
                    r_key[w_map_idx] <= ~r_brk;
                end
            end
        end
    end

    logic [39:0] w_matrix;

`ifdef PS2_EXTKEYS_EN
    // Held composite keys: left, right, down, up, backspace, right ctrl.
    logic [5:0]  r_cmp;
    logic [5:0]  w_cmp_sel;
    logic [39:0] w_cmp_key;

    always_comb begin
        w_cmp_sel = '0;
        if (r_ext) begin
            case (r_rx_byte)
                8'h6B:   w_cmp_sel[0] = 1'b1;
                8'h74:   w_cmp_sel[1] = 1'b1;
                8'h72:   w_cmp_sel[2] = 1'b1;
                8'h75:   w_cmp_sel[3] = 1'b1;
                8'h14:   w_cmp_sel[5] = 1'b1;
                default: w_cmp_sel    = '0;
            endcase
        end else if (r_rx_byte == 8'h66) begin
            w_cmp_sel[4] = 1'b1;
        end
    end

    always_ff @(posedge clkcpu or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp <= '0;
        end else if (w_key_ev) begin
            r_cmp <= r_brk ? (r_cmp & ~w_cmp_sel) : (r_cmp | w_cmp_sel);
        end
    end

    always_comb begin
        w_cmp_key     = '0;
        w_cmp_key[0]  = |r_cmp[4:0];
        w_cmp_key[19] = r_cmp[0];
        w_cmp_key[22] = r_cmp[1];
        w_cmp_key[24] = r_cmp[2];
        w_cmp_key[23] = r_cmp[3];
        w_cmp_key[20] = r_cmp[4];
        w_cmp_key[36] = r_cmp[5];
    end

    assign w_matrix = r_key | w_cmp_key;
`else
    assign w_matrix = r_key;
`endif

    logic [4:0] w_col_any;

    always_comb begin
        w_col_any = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi[r]) w_col_any = w_col_any | w_matrix[r*5 +: 5];
        end
    end

    assign kd      = ~w_col_any;
    assign key_rst = r_key_rst;

endmodule
